// File: rtl/bram_vector_fetch.sv
// Read-command initiator: streams input vectors from BRAM_CTRL and fetches the template/FF/TC
// words on each template-selector change. Define BRAM_VECTOR_FETCH_TC_EN to include the TC fetch.
module bram_vector_fetch #(
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [COUNT_WIDTH-1:0] VECTOR_COUNT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERROR,
  output logic                   INPUT_READ,
  output logic                   TEMPLATE_READ,
  output logic                   FF_READ,
  output logic                   TC_READ,
  output logic [1:0]             TEMPLATE_BITS,
  input  logic [DATA_WIDTH-1:0]  READ_DATA_0,
  input  logic [DATA_WIDTH-1:0]  READ_DATA_1,
  input  logic                   READY,
  output logic [DATA_WIDTH-1:0]  VEC_DATA,
  output logic [DATA_WIDTH-1:0]  TMPL_DATA,
  output logic [DATA_WIDTH-1:0]  FF_DATA_0,
  output logic [DATA_WIDTH-1:0]  FF_DATA_1,
  output logic [DATA_WIDTH-1:0]  TC_DATA,
  output logic                   VEC_VALID,
  input  logic                   VEC_ACCEPT
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_IN_REQ, S_IN_WAIT, S_TMPL_REQ, S_TMPL_WAIT, S_FF_REQ, S_FF_WAIT,
`ifdef BRAM_VECTOR_FETCH_TC_EN
    S_TC_REQ, S_TC_WAIT,
`endif
    S_PRESENT, S_FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    holdoff_q, holdoff_d;
  logic                    error_q, error_d;
  logic                    cache_vld_q, cache_vld_d;
  logic [1:0]              tbits_q, tbits_d;
  logic [DATA_WIDTH-1:0]   vec_q, vec_d, tmpl_q, tmpl_d, ff0_q, ff0_d, ff1_q, ff1_d;
`ifdef BRAM_VECTOR_FETCH_TC_EN
  logic [DATA_WIDTH-1:0]   tc_q, tc_d;
`endif
  logic                    is_wait, captured, timed_out;
  logic [1:0]              rd_sel;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      holdoff_q   <= 1'b0;
      error_q     <= 1'b0;
      cache_vld_q <= 1'b0;
      tbits_q     <= '0;
      vec_q       <= '0;
      tmpl_q      <= '0;
      ff0_q       <= '0;
      ff1_q       <= '0;
`ifdef BRAM_VECTOR_FETCH_TC_EN
      tc_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      holdoff_q   <= holdoff_d;
      error_q     <= error_d;
      cache_vld_q <= cache_vld_d;
      tbits_q     <= tbits_d;
      vec_q       <= vec_d;
      tmpl_q      <= tmpl_d;
      ff0_q       <= ff0_d;
      ff1_q       <= ff1_d;
`ifdef BRAM_VECTOR_FETCH_TC_EN
      tc_q        <= tc_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    holdoff_d     = holdoff_q;
    error_d       = error_q;
    cache_vld_d   = cache_vld_q;
    tbits_d       = tbits_q;
    vec_d         = vec_q;
    tmpl_d        = tmpl_q;
    ff0_d         = ff0_q;
    ff1_d         = ff1_q;
`ifdef BRAM_VECTOR_FETCH_TC_EN
    tc_d          = tc_q;
`endif
    INPUT_READ    = 1'b0;
    TEMPLATE_READ = 1'b0;
    FF_READ       = 1'b0;
    TC_READ       = 1'b0;
    rd_sel        = READ_DATA_0[DATA_WIDTH-1 -: 2];

    is_wait = (state_q == S_IN_WAIT) || (state_q == S_TMPL_WAIT) || (state_q == S_FF_WAIT);
`ifdef BRAM_VECTOR_FETCH_TC_EN
    if (state_q == S_TC_WAIT) is_wait = 1'b1;
`endif
    // The first wait cycle is a hold-off: BRAM_CTRL drops READY one cycle after the pulse.
    captured  = is_wait && !holdoff_q && READY;
    timed_out = is_wait && !captured && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
    if (is_wait) begin
      holdoff_d = 1'b0;
      wait_d    = wait_q + 1'b1;
    end else begin
      holdoff_d = 1'b1;
      wait_d    = '0;
    end

    case (state_q)
      S_IDLE: if (START) begin
        cnt_d       = VECTOR_COUNT;
        error_d     = 1'b0;
        cache_vld_d = 1'b0;
        state_d     = (VECTOR_COUNT == '0) ? S_FINISH : S_IN_REQ;
      end
      S_IN_REQ: if (READY) begin
        INPUT_READ = 1'b1;
        state_d    = S_IN_WAIT;
      end
      S_IN_WAIT: if (captured) begin
        vec_d = READ_DATA_0;
        // TEMPLATE_BITS doubles as the cached selector once the cache is valid.
        if (!cache_vld_q || rd_sel != tbits_q) begin
          cache_vld_d = 1'b0;
          tbits_d     = rd_sel;
          state_d     = S_TMPL_REQ;
        end else begin
          state_d = S_PRESENT;
        end
      end
      S_TMPL_REQ: if (READY) begin
        TEMPLATE_READ = 1'b1;
        state_d       = S_TMPL_WAIT;
      end
      S_TMPL_WAIT: if (captured) begin
        tmpl_d  = READ_DATA_0;
        state_d = S_FF_REQ;
      end
      S_FF_REQ: if (READY) begin
        FF_READ = 1'b1;
        state_d = S_FF_WAIT;
      end
      S_FF_WAIT: if (captured) begin
        ff0_d = READ_DATA_0;
        ff1_d = READ_DATA_1;
`ifdef BRAM_VECTOR_FETCH_TC_EN
        state_d = S_TC_REQ;
`else
        cache_vld_d = 1'b1;
        state_d     = S_PRESENT;
`endif
      end
`ifdef BRAM_VECTOR_FETCH_TC_EN
      S_TC_REQ: if (READY) begin
        TC_READ = 1'b1;
        state_d = S_TC_WAIT;
      end
      S_TC_WAIT: if (captured) begin
        tc_d        = READ_DATA_0;
        cache_vld_d = 1'b1;
        state_d     = S_PRESENT;
      end
`endif
      S_PRESENT: if (VEC_ACCEPT) begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == COUNT_WIDTH'(1)) ? S_FINISH : S_IN_REQ;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (timed_out) begin
      error_d = 1'b1;
      state_d = S_FINISH;
    end
  end

  assign BUSY          = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign DONE          = (state_q == S_FINISH);
  assign VEC_VALID     = (state_q == S_PRESENT);
  assign ERROR         = error_q;
  assign TEMPLATE_BITS = tbits_q;
  assign VEC_DATA      = vec_q;
  assign TMPL_DATA     = tmpl_q;
  assign FF_DATA_0     = ff0_q;
  assign FF_DATA_1     = ff1_q;
`ifdef BRAM_VECTOR_FETCH_TC_EN
  assign TC_DATA       = tc_q;
`else
  assign TC_DATA       = '0;
`endif

endmodule

// File: tb/tb_bram_vector_fetch.sv
// Scoreboard bench for bram_vector_fetch with a behavioural BRAM_CTRL responder.
module tb_bram_vector_fetch;
  localparam int DW = 128;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RST, START, READY, VEC_ACCEPT;
  logic [CW-1:0] VECTOR_COUNT;
  logic          BUSY, DONE, ERROR, INPUT_READ, TEMPLATE_READ, FF_READ, TC_READ, VEC_VALID;
  logic [1:0]    TEMPLATE_BITS;
  logic [DW-1:0] READ_DATA_0, READ_DATA_1, VEC_DATA, TMPL_DATA, FF_DATA_0, FF_DATA_1, TC_DATA;

  always #5 CLK = ~CLK;

  bram_vector_fetch #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .VECTOR_COUNT(VECTOR_COUNT), .BUSY(BUSY), .DONE(DONE),
    .ERROR(ERROR), .INPUT_READ(INPUT_READ), .TEMPLATE_READ(TEMPLATE_READ), .FF_READ(FF_READ),
    .TC_READ(TC_READ), .TEMPLATE_BITS(TEMPLATE_BITS), .READ_DATA_0(READ_DATA_0),
    .READ_DATA_1(READ_DATA_1), .READY(READY), .VEC_DATA(VEC_DATA), .TMPL_DATA(TMPL_DATA),
    .FF_DATA_0(FF_DATA_0), .FF_DATA_1(FF_DATA_1), .TC_DATA(TC_DATA), .VEC_VALID(VEC_VALID),
    .VEC_ACCEPT(VEC_ACCEPT)
  );

  typedef struct { logic [DW-1:0] v, t, f0, f1, tc; } bundle_t;
  typedef struct { int unsigned kind; logic [1:0] bits; } cmd_t;

  bundle_t       exp_b[$];
  cmd_t          exp_c[$];
  logic          exp_d[$];
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] tmpl_tab[4], ff0_tab[4], ff1_tab[4], tc_tab[4];

  int          checks = 0, failures = 0;
  int unsigned cyc = 0, tmpl_cnt = 0, done_cnt = 0, last_cmd_cyc = 0, done_cyc = 0;
  logic        stuck = 1'b0, drop_next = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // BRAM_CTRL model: data follows the pulse; in stuck mode READY drops one cycle late.
  initial begin : responder
    int unsigned rk;
    logic [1:0]  rb;
    READY = 1'b1; READ_DATA_0 = '0; READ_DATA_1 = '0;
    forever begin
      @(negedge CLK);
      rk = 4; rb = TEMPLATE_BITS;
      if (INPUT_READ) rk = 0; else if (TEMPLATE_READ) rk = 1; else if (FF_READ) rk = 2;
      else if (TC_READ) rk = 3;
      #1;
      if (!stuck) READY = 1'b1;
      else if (drop_next) begin READY = 1'b0; drop_next = 1'b0; end
      case (rk)
        0: begin READ_DATA_0 = (in_q.size() != 0) ? in_q.pop_front() : '0; READ_DATA_1 = '0; end
        1: READ_DATA_0 = tmpl_tab[rb];
        2: begin READ_DATA_0 = ff0_tab[rb]; READ_DATA_1 = ff1_tab[rb]; end
        3: READ_DATA_0 = tc_tab[rb];
        default: ;
      endcase
      if (rk != 4 && stuck) drop_next = 1'b1;
    end
  end

  int unsigned m_n, m_k;
  cmd_t        m_c;
  bundle_t     m_b;
  logic        m_e;
  always @(negedge CLK) begin
    if (!RST) begin
      m_n = int'(INPUT_READ) + int'(TEMPLATE_READ) + int'(FF_READ) + int'(TC_READ);
      if (m_n != 0) begin
        check("cmd_onehot", m_n, 1);
        m_k = INPUT_READ ? 0 : TEMPLATE_READ ? 1 : FF_READ ? 2 : 3;
        last_cmd_cyc = cyc;
        if (TEMPLATE_READ) tmpl_cnt++;
        if (exp_c.size() == 0) check("cmd_expected_pending", exp_c.size(), 1);
        else begin
          m_c = exp_c.pop_front();
          check("cmd_kind", m_k, m_c.kind);
          if (m_k != 0) check("cmd_template_bits", TEMPLATE_BITS, m_c.bits);
        end
      end
      if (VEC_VALID && VEC_ACCEPT) begin
        if (exp_b.size() == 0) check("bundle_expected_pending", exp_b.size(), 1);
        else begin
          m_b = exp_b.pop_front();
          check("vec_data", VEC_DATA, m_b.v);
          check("tmpl_data", TMPL_DATA, m_b.t);
          check("ff_data_0", FF_DATA_0, m_b.f0);
          check("ff_data_1", FF_DATA_1, m_b.f1);
          check("tc_data", TC_DATA, m_b.tc);
        end
      end
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_d.size() == 0) check("done_expected_pending", exp_d.size(), 1);
        else begin
          m_e = exp_d.pop_front();
          check("done_error", ERROR, m_e);
          check("done_busy", BUSY, 0);
        end
      end
    end
  end

  task automatic exp_cmd(input int unsigned k, input logic [1:0] b);
    cmd_t c;
    c.kind = k; c.bits = b;
    exp_c.push_back(c);
  endtask

  task automatic exp_fetch(input logic [1:0] s);
    exp_cmd(1, s);
    exp_cmd(2, s);
`ifdef BRAM_VECTOR_FETCH_TC_EN
    exp_cmd(3, s);
`endif
  endtask

  task automatic exp_vec(input logic [DW-1:0] v, input logic [1:0] s);
    bundle_t b;
    in_q.push_back(v);
    b.v = v; b.t = tmpl_tab[s]; b.f0 = ff0_tab[s]; b.f1 = ff1_tab[s];
`ifdef BRAM_VECTOR_FETCH_TC_EN
    b.tc = tc_tab[s];
`else
    b.tc = '0;
`endif
    exp_b.push_back(b);
  endtask

  task automatic start_run(input logic [CW-1:0] n);
    @(posedge CLK); #1;
    VECTOR_COUNT = n; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned d0, input int unsigned bound);
    int unsigned k = 0;
    while (done_cnt == d0 && k < bound) begin @(negedge CLK); #1; k++; end
    check({name, "_done_count"}, done_cnt - d0, 1);
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge CLK);
    check({name, "_cmd_queue_empty"}, exp_c.size(), 0);
    check({name, "_bundle_queue_empty"}, exp_b.size(), 0);
    check({name, "_done_queue_empty"}, exp_d.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin : stim
    int unsigned d0, k;
    logic [DW-1:0] v0, v1, v2, v3, v4, v5, v6;
    tmpl_tab[0] = 128'hA0A0_0000_0000_0000_0000_0000_0000_0100;
    tmpl_tab[1] = 128'hA1A1_0000_0000_0000_0000_0000_0000_0101;
    tmpl_tab[2] = 128'hA2A2_0000_0000_0000_0000_0000_0000_0102;
    tmpl_tab[3] = 128'hA3A3_0000_0000_0000_0000_0000_0000_0103;
    ff0_tab[0]  = 128'hF000_1111_0000_0000_0000_0000_0000_0200;
    ff0_tab[1]  = 128'hF001_1111_0000_0000_0000_0000_0000_0201;
    ff0_tab[2]  = 128'hF002_1111_0000_0000_0000_0000_0000_0202;
    ff0_tab[3]  = 128'hF003_1111_0000_0000_0000_0000_0000_0203;
    ff1_tab[0]  = 128'hF100_2222_0000_0000_0000_0000_0000_0300;
    ff1_tab[1]  = 128'hF101_2222_0000_0000_0000_0000_0000_0301;
    ff1_tab[2]  = 128'hF102_2222_0000_0000_0000_0000_0000_0302;
    ff1_tab[3]  = 128'hF103_2222_0000_0000_0000_0000_0000_0303;
    tc_tab[0]   = 128'hCC00_3333_0000_0000_0000_0000_0000_0400;
    tc_tab[1]   = 128'hCC01_3333_0000_0000_0000_0000_0000_0401;
    tc_tab[2]   = 128'hCC02_3333_0000_0000_0000_0000_0000_0402;
    tc_tab[3]   = 128'hCC03_3333_0000_0000_0000_0000_0000_0403;
    v0 = 128'h0123_FEED_0000_0000_0000_0000_0000_0001;
    v1 = 128'hC123_FEED_0000_0000_0000_0000_0000_0002;
    v2 = 128'h1123_FEED_0000_0000_0000_0000_0000_0003;
    v3 = 128'h3ABC_FEED_0000_0000_0000_0000_0000_0004;
    v4 = 128'h4123_FEED_0000_0000_0000_0000_0000_0005;
    v5 = 128'h2000_BEEF_0000_0000_0000_0000_0000_0006;
    v6 = 128'h8123_FEED_0000_0000_0000_0000_0000_0007;

    RST = 1'b1; START = 1'b0; VECTOR_COUNT = '0; VEC_ACCEPT = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_ctrl", {BUSY, DONE, ERROR, INPUT_READ, TEMPLATE_READ, FF_READ, TC_READ,
                         TEMPLATE_BITS, VEC_VALID}, 0);
    check("reset_data", VEC_DATA | TMPL_DATA | FF_DATA_0 | FF_DATA_1 | TC_DATA, 0);
    @(posedge CLK); #1; RST = 1'b0;

    // Zero-length run; START held into the DONE cycle must not launch a second run.
    d0 = done_cnt;
    exp_d.push_back(1'b0);
    @(posedge CLK); #1; VECTOR_COUNT = '0; START = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1; START = 1'b0;
    wait_done("zero_count", d0, 4);
    drain("zero_count");
    check("zero_count_single_done", done_cnt - d0, 1);
    check("zero_count_error", ERROR, 0);

    // Two vectors with selectors 0 then 3.
    d0 = done_cnt;
    exp_cmd(0, 2'd0); exp_fetch(2'd0); exp_cmd(0, 2'd0); exp_fetch(2'd3);
    exp_vec(v0, 2'd0); exp_vec(v1, 2'd3);
    exp_d.push_back(1'b0);
    start_run(2);
    wait_done("two_vec", d0, 60);
    drain("two_vec");

    // Three vectors sharing selector 0: a single template fetch; START while busy is ignored.
    d0 = done_cnt;
    exp_cmd(0, 2'd0); exp_fetch(2'd0); exp_cmd(0, 2'd0); exp_cmd(0, 2'd0);
    exp_vec(v0, 2'd0); exp_vec(v2, 2'd0); exp_vec(v3, 2'd0);
    exp_d.push_back(1'b0);
    start_run(3);
    @(posedge CLK); #1; VECTOR_COUNT = 16'd7; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    wait_done("same_sel", d0, 80);
    drain("same_sel");

    // Driver back-pressure: bundle must hold steady with no command traffic.
    d0 = done_cnt;
    VEC_ACCEPT = 1'b0;
    exp_cmd(0, 2'd0); exp_fetch(2'd1); exp_vec(v4, 2'd1);
    exp_d.push_back(1'b0);
    start_run(1);
    k = 0;
    while (!VEC_VALID && k < 40) begin @(negedge CLK); #1; k++; end
    check("hold_present_reached", VEC_VALID, 1);
    repeat (20) begin
      @(negedge CLK); #1;
      check("hold_vec_valid", VEC_VALID, 1);
      check("hold_vec_data", VEC_DATA, v4);
      check("hold_tmpl_data", TMPL_DATA, tmpl_tab[1]);
    end
    check("hold_no_new_cmd", exp_c.size(), 0);
    @(posedge CLK); #1; VEC_ACCEPT = 1'b1;
    wait_done("hold", d0, 10);
    drain("hold");

    // READY stuck low after the input read: timeout aborts with ERROR.
    d0 = done_cnt;
    stuck = 1'b1;
    in_q.push_back(v5);
    exp_cmd(0, 2'd0);
    exp_d.push_back(1'b1);
    start_run(1);
    wait_done("timeout", d0, 40);
    check("timeout_latency_in_range",
          ((done_cyc - last_cmd_cyc) >= 16) && ((done_cyc - last_cmd_cyc) <= 18), 1);
    drain("timeout");
    check("timeout_error_sticky", ERROR, 1);
    check("timeout_busy", BUSY, 0);
    stuck = 1'b0;
    repeat (3) @(posedge CLK);

    // Reset while waiting on the template read, then a clean rerun.
    k = tmpl_cnt;
    exp_cmd(0, 2'd0); exp_cmd(1, 2'd2);
    in_q.push_back(v6);
    start_run(1);
    check("start_clears_error", ERROR, 0);
    d0 = 0;
    while (tmpl_cnt == k && d0 < 30) begin @(negedge CLK); #1; d0++; end
    check("rst_tmpl_pulse_seen", tmpl_cnt - k, 1);
    @(posedge CLK); #1; RST = 1'b1; #1;
    check("midrun_rst_ctrl", {BUSY, DONE, ERROR, INPUT_READ, TEMPLATE_READ, FF_READ, TC_READ,
                              TEMPLATE_BITS, VEC_VALID}, 0);
    check("midrun_rst_data", VEC_DATA | TMPL_DATA | FF_DATA_0 | FF_DATA_1 | TC_DATA, 0);
    exp_c.delete(); exp_b.delete(); exp_d.delete(); in_q.delete();
    @(posedge CLK); #1; RST = 1'b0;
    d0 = done_cnt;
    exp_cmd(0, 2'd0); exp_fetch(2'd2); exp_vec(v6, 2'd2);
    exp_d.push_back(1'b0);
    start_run(1);
    wait_done("after_rst", d0, 40);
    drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
